// File: rtl/rom_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rom_port_arbiter_pkg : shared types and constants for the ROM port arbiter
// Revision: 1.0
// ============================================================================
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rom_arb_state_e;

    localparam int STATS_CNT_WIDTH = 16;

    function automatic int rr_idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_arb_rr.sv
`default_nettype none
// ============================================================================
// rom_arb_rr : combinational round-robin picker (first request at/after ptr)
// Revision: 1.0
// ============================================================================
module rom_arb_rr
    import rom_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = rr_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        int w_cand;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (int'(i_ptr) + i) % NUM_REQ;
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// rom_port_arbiter : round-robin sharing of the ROM accel read port, with
// local range check and response timeout. Optional grant/error statistics
// under ROM_PORT_ARBITER_STATS_EN.
// Revision: 1.0
// ============================================================================
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int ROM_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_REQ-1:0]                      req_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]      addr_i,
    output logic [NUM_REQ-1:0]                      gnt_o,
    output logic [NUM_REQ-1:0]                      rvalid_o,
    output logic [DATA_WIDTH-1:0]                   rdata_o,
    output logic                                    rerr_o,
    output logic                                    rom_req_o,
    output logic [ADDR_WIDTH-1:0]                   rom_addr_o,
    input  logic [DATA_WIDTH-1:0]                   rom_data_i,
    input  logic                                    rom_valid_i,
`ifdef ROM_PORT_ARBITER_STATS_EN
    output logic [NUM_REQ-1:0][STATS_CNT_WIDTH-1:0] grant_cnt_o,
    output logic [STATS_CNT_WIDTH-1:0]              err_cnt_o,
`endif
    output logic                                    busy_o
);

    localparam int IDX_W = rr_idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      c_TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] c_ROM_DEPTH = ADDR_WIDTH'(ROM_DEPTH);
    localparam logic [IDX_W-1:0]      c_LAST_IDX  = IDX_W'(NUM_REQ - 1);

    rom_arb_state_e          r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_owner;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_REQ-1:0]      r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_rerr;
    logic                    r_rom_req;

    logic [NUM_REQ-1:0]      w_gnt;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_any;
    logic                    w_idle;
    logic [ADDR_WIDTH-1:0]   w_win_addr;
    logic                    w_in_range;
    logic [NUM_REQ-1:0]      w_owner_oh;

    rom_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_idle     = (r_state == IDLE);
    assign w_win_addr = addr_i[w_idx];
    // Full-width compare so a set upper bit can never alias into the ROM.
    assign w_in_range = (w_win_addr < c_ROM_DEPTH);
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    assign gnt_o      = (w_idle && rst_ni) ? w_gnt : '0;
    assign rvalid_o   = r_rvalid;
    assign rdata_o    = r_rdata;
    assign rerr_o     = r_rerr;
    assign rom_req_o  = r_rom_req;
    assign rom_addr_o = r_addr;
    assign busy_o     = !w_idle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
            r_rerr    <= 1'b0;
            r_rom_req <= 1'b0;
        end else begin
            // Response and ROM strobes are single-cycle unless re-asserted below.
            r_rom_req <= 1'b0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
            r_rerr    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_idx;
                        r_addr  <= w_win_addr;
                        r_ptr   <= (w_idx == c_LAST_IDX) ? '0 : w_idx + 1'b1;
                        if (w_in_range) begin
                            r_state   <= ISSUE;
                            r_rom_req <= 1'b1;
                        end else begin
                            r_state  <= RESP;
                            r_rvalid <= w_gnt;
                            r_rerr   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                    r_cnt   <= '0;
                end
                WAIT: begin
                    if (rom_valid_i) begin
                        r_state  <= RESP;
                        r_rvalid <= w_owner_oh;
                        r_rdata  <= rom_data_i;
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_state  <= RESP;
                        r_rvalid <= w_owner_oh;
                        r_rerr   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROM_PORT_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][STATS_CNT_WIDTH-1:0] r_grant_cnt;
    logic [STATS_CNT_WIDTH-1:0]              r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_o[i] && (r_grant_cnt[i] != '1)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
                end
            end
            if ((|r_rvalid) && r_rerr && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign grant_cnt_o = r_grant_cnt;
    assign err_cnt_o   = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rom_port_arbiter : scoreboard bench for rom_port_arbiter with a
// transaction-level arbitration model and a behavioural ROM (byte i = i+1).
// Revision: 1.0
// ============================================================================
module tb_rom_port_arbiter;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 4;

    logic                 clk    = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [N-1:0]         req_i  = '0;
    logic [N-1:0][AW-1:0] addr_i = '0;
    logic [N-1:0]         gnt_o;
    logic [N-1:0]         rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic                 rerr_o;
    logic                 rom_req_o;
    logic [AW-1:0]        rom_addr_o;
    logic [DW-1:0]        rom_data_i  = '0;
    logic                 rom_valid_i = 1'b0;
    logic                 busy_o;
`ifdef ROM_PORT_ARBITER_STATS_EN
    logic [N-1:0][15:0]   grant_cnt_o;
    logic [15:0]          err_cnt_o;
`endif

    rom_port_arbiter #(
        .NUM_REQ        (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .ROM_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .rerr_o      (rerr_o),
        .rom_req_o   (rom_req_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .rom_valid_i (rom_valid_i),
`ifdef ROM_PORT_ARBITER_STATS_EN
        .grant_cnt_o (grant_cnt_o),
        .err_cnt_o   (err_cnt_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        int            owner;
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } romx_t;

    resp_t rq[$];
    romx_t xq[$];

    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  pend   = '0;
    logic [AW-1:0] paddr [N];
    logic [N-1:0]  exp_gnt = '0;
    int            ptr = 0, next_idle = 0, busy_from = 1, busy_until = 0;
    bit            sup_cur = 1'b0, refill = 1'b0, stray = 1'b0;
    int            sup_mode = 0;
    logic          rst_want = 1'b0;
    logic          seen_req;
    logic [AW-1:0] seen_addr;
    resp_t         mon_r;
    romx_t         mon_x;
    bit            mon_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(gnt_o == '0,      {tag, "_gnt"},      64'(gnt_o),      64'(0));
        chk(rvalid_o == '0,   {tag, "_rvalid"},   64'(rvalid_o),   64'(0));
        chk(rdata_o == '0,    {tag, "_rdata"},    64'(rdata_o),    64'(0));
        chk(rerr_o == 1'b0,   {tag, "_rerr"},     64'(rerr_o),     64'(0));
        chk(rom_req_o == 1'b0,{tag, "_rom_req"},  64'(rom_req_o),  64'(0));
        chk(rom_addr_o == '0, {tag, "_rom_addr"}, 64'(rom_addr_o), 64'(0));
        chk(busy_o == 1'b0,   {tag, "_busy"},     64'(busy_o),     64'(0));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom % 5)
            0, 1:    return AW'($urandom_range(0, DEPTH - 1));
            2:       return ($urandom % 2 == 0) ? AW'(DEPTH - 1) : AW'(DEPTH);
            3:       return AW'($urandom);
            default: return (AW'(1) << $urandom_range(4, AW - 1)) | AW'($urandom % DEPTH);
        endcase
    endfunction

    // Transaction-level view: a free arbiter picks the first pending requester
    // from ptr; each transaction occupies the port for a fixed latency.
    task automatic model_step();
        int            w;
        int            lat;
        logic [AW-1:0] a;
        resp_t         r;
        romx_t         x;
        exp_gnt = '0;
        if (cyc < next_idle || pend == '0) return;
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
        exp_gnt[w] = 1'b1;
        a = paddr[w];
        r.owner = w;
        if (a < AW'(DEPTH)) begin
            sup_cur = (sup_mode == 1) || (sup_mode == 2 && $urandom % 5 == 0);
            x.cyc  = cyc + 1;
            x.addr = a;
            xq.push_back(x);
            if (sup_cur) begin
                lat = TO + 3; r.data = '0; r.err = 1'b1;
            end else begin
                lat = 3; r.data = DW'(a + 1); r.err = 1'b0;
            end
        end else begin
            lat = 1; r.data = '0; r.err = 1'b1;
        end
        r.cyc = cyc + lat;
        rq.push_back(r);
        busy_from  = cyc + 1;
        busy_until = cyc + lat;
        next_idle  = cyc + lat + 1;
        ptr        = (w + 1) % N;
        pend[w]    = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        seen_req  = rom_req_o;
        seen_addr = rom_addr_o;
        @(posedge clk);
        #1;
        rst_ni = rst_want;
        if (refill) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom % 3 == 0) begin
                    pend[i]  = 1'b1;
                    paddr[i] = rand_addr();
                end
            end
        end
        req_i = pend;
        for (int i = 0; i < N; i++) addr_i[i] = paddr[i];
        if (seen_req && !sup_cur) begin
            rom_valid_i = 1'b1;
            rom_data_i  = DW'(seen_addr + 1);
        end else if (stray && cyc >= next_idle && $urandom % 4 == 0) begin
            rom_valid_i = 1'b1;
            rom_data_i  = DW'($urandom);
        end else begin
            rom_valid_i = 1'b0;
            rom_data_i  = DW'($urandom);
        end
        if (rst_ni) model_step();
        else exp_gnt = '0;
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            chk(gnt_o == exp_gnt, "gnt", 64'(gnt_o), 64'(exp_gnt));
            mon_busy = (cyc >= busy_from) && (cyc <= busy_until);
            chk(busy_o == mon_busy, "busy", 64'(busy_o), 64'(mon_busy));
            if (rvalid_o != '0) begin
                if (rq.size() == 0) begin
                    chk(1'b0, "rvalid_unexpected", 64'(rvalid_o), 64'(0));
                end else begin
                    mon_r = rq.pop_front();
                    chk(mon_r.cyc == cyc, "rvalid_cycle", 64'(cyc), 64'(mon_r.cyc));
                    chk(rvalid_o == (N'(1) << mon_r.owner), "rvalid_owner",
                        64'(rvalid_o), 64'(N'(1) << mon_r.owner));
                    chk(rdata_o == mon_r.data, "rdata", 64'(rdata_o), 64'(mon_r.data));
                    chk(rerr_o == mon_r.err, "rerr", 64'(rerr_o), 64'(mon_r.err));
                end
            end else begin
                chk(rdata_o == '0 && rerr_o == 1'b0, "resp_idle_zero",
                    64'({rdata_o, rerr_o}), 64'(0));
                if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                    chk(1'b0, "rvalid_missing", 64'(0), 64'(rq[0].cyc));
                    mon_r = rq.pop_front();
                end
            end
            if (rom_req_o) begin
                if (xq.size() == 0) begin
                    chk(1'b0, "rom_req_unexpected", 64'(rom_addr_o), 64'(0));
                end else begin
                    mon_x = xq.pop_front();
                    chk(mon_x.cyc == cyc, "rom_req_cycle", 64'(cyc), 64'(mon_x.cyc));
                    chk(rom_addr_o == mon_x.addr, "rom_addr", 64'(rom_addr_o), 64'(mon_x.addr));
                end
            end else if (xq.size() > 0 && xq[0].cyc <= cyc) begin
                chk(1'b0, "rom_req_missing", 64'(0), 64'(xq[0].cyc));
                mon_x = xq.pop_front();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) paddr[i] = AW'(i);
        // All four requesters hold from reset: expect grants 0,1,2,3
        pend     = 4'b1111;
        rst_want = 1'b0;
        repeat (3) step();
        chk_zero("reset");
        rst_want = 1'b1;
        repeat (18) step();

        pend[0] = 1'b1; paddr[0] = AW'(5);
        repeat (6) step();
        pend[2] = 1'b1; paddr[2] = AW'(16);
        repeat (4) step();
        // Pointer now at 3: requester 3 then 0
        pend = 4'b1001; paddr[3] = AW'(9); paddr[0] = AW'(15);
        repeat (10) step();
        pend[1] = 1'b1; paddr[1] = 32'h8000_0002;
        repeat (4) step();

        // Timeout on a suppressed ROM, then a normal read
        sup_mode = 1; pend[1] = 1'b1; paddr[1] = AW'(3);
        step();
        sup_mode = 0;
        repeat (9) step();
        pend[3] = 1'b1; paddr[3] = AW'(3);
        repeat (6) step();

        // Reset while waiting on the ROM
        sup_mode = 1; pend[1] = 1'b1; paddr[1] = AW'(3);
        step();
        repeat (3) step();
        #2;
        rst_want = 1'b0;
        rst_ni   = 1'b0;
        #1;
        chk_zero("midreset");
        rq.delete();
        xq.delete();
        ptr = 0; next_idle = 0; busy_from = 1; busy_until = 0;
        exp_gnt = '0; sup_mode = 0; sup_cur = 1'b0;
        pend = 4'b0011; paddr[0] = AW'(7); paddr[1] = AW'(8);
        repeat (2) step();
        rst_want = 1'b1;
        repeat (12) step();

        refill = 1'b1; stray = 1'b1; sup_mode = 2;
        repeat (600) step();
        refill = 1'b0; stray = 1'b0;
        repeat (50) step();
        chk(rq.size() == 0, "resp_drained", 64'(rq.size()), 64'(0));
        chk(xq.size() == 0, "rom_drained", 64'(xq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the user-domain ROM's single 8-bit accelerator read port between NumReq accelerator requesters.
- Round-robin arbitration; exactly one transaction in flight.
- Addresses outside the ROM are rejected locally with an error; the ROM is not accessed for them.
- A missing ROM valid is caught by a timeout and returned as an error.
- Sits between accelerator masters and the ROM's accel_req/accel_addr/accel_data/accel_valid port.

Parameters:
- NumReq, 4, number of requesters (2..8)
- AddrWidth, 32, requester and ROM address width
- DataWidth, 8, ROM read data width
- RomDepth, 16, number of valid byte addresses (0..RomDepth-1)
- TimeoutCycles, 4, WAIT-state cycles without rom_valid_i before error response (>=2)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  NumReq  per-requester request; held with addr until gnt
- addr_i  input  NumReq x AddrWidth  per-requester byte address
- gnt_o  output  NumReq  one-hot grant, combinational, IDLE only
- rvalid_o  output  NumReq  one-hot response valid, registered, 1 cycle
- rdata_o  output  DataWidth  shared response data, qualified by rvalid_o
- rerr_o  output  1  response error, qualified by rvalid_o
- rom_req_o  output  1  ROM port request, registered, 1-cycle pulse
- rom_addr_o  output  AddrWidth  ROM port address, stable while busy
- rom_data_i  input  DataWidth  ROM read data
- rom_valid_i  input  1  ROM data valid (1 cycle after rom_req_o)
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, RR pointer=0, timeout counter=0, owner=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner is the first asserted req_i at or after the pointer, searching upward with wrap.
  - gnt_o[winner]=1 in the same cycle.
  - Captured on the clock edge: owner, addr.
  - Pointer becomes (winner+1) mod NumReq.
  - addr < RomDepth -> ISSUE; otherwise -> RESP with err=1, data=0.
- ISSUE: rom_req_o=1 for exactly this cycle, rom_addr_o=captured addr -> WAIT.
- WAIT:
  - rom_valid_i=1 -> latch rom_data_i, err=0 -> RESP.
  - Otherwise the counter increments; on reaching TimeoutCycles -> RESP with err=1, data=0.
  - The counter clears on entry to WAIT.
- RESP: rvalid_o[owner]=1, rdata_o and rerr_o driven for this cycle only -> IDLE.
- Latency:
  - In-range: gnt at T0, rom_req T1, rom_valid T2, rvalid T3.
  - Out-of-range: rvalid T1.
  - Peak throughput: one transaction per 4 cycles.
- rdata_o and rerr_o are 0 whenever rvalid_o is 0.
- rom_valid_i outside WAIT is ignored.
- No gnt outside IDLE. Requests arriving while busy wait; they are not dropped.
- Simultaneous requests: strictly round-robin, so each requester waits at most NumReq-1 transactions.
- Address compare is done on the full AddrWidth value; upper bits are not truncated.
- Reset mid-transaction: immediate return to IDLE, outputs cleared, pointer=0. The in-flight response is lost.

Optional Feature:
- Macro: ROM_PORT_ARBITER_STATS_EN.
- Enabled:
  - Adds output grant_cnt_o (NumReq x 16), per-requester saturating grant counters, reset 0.
  - Adds output err_cnt_o (16), a saturating count of error responses, reset 0.
  - Counters increment on gnt and on error rvalid respectively.
- Disabled: these ports and registers are absent. Functional behaviour is identical.

Decomposition:
- Package rom_port_arbiter_pkg holds:
  - FSM state enum rom_arb_state_e (IDLE, ISSUE, WAIT, RESP).
  - Counter width constant StatsCntWidth=16.
  - Function for the RR winner index width, clog2 of NumReq.
- Sub-module rom_arb_rr: combinational round-robin picker, inputs req vector and pointer, outputs one-hot grant and winner index. The pointer register stays in the parent.

Test Plan:
- ROM byte i=i+1. Single request: req_i[0]=1, addr 5 -> gnt_o[0] at T0, rom_req_o at T1 with addr 5, rvalid_o[0] at T3, rdata_o=0x06, rerr_o=0.
- Contention: all 4 requesters hold req from reset with addrs 0,1,2,3 -> grant order 0,1,2,3. rdata sequence 0x01,0x02,0x03,0x04; gnts spaced 4 cycles apart.
- Out-of-range: req_i[2]=1, addr 16 -> gnt T0, rvalid_o[2] at T1, rerr_o=1, rdata_o=0, rom_req_o never asserted.
- Timeout: ROM model suppresses rom_valid_i, addr 3 -> rvalid at T1+1+TimeoutCycles+1 (T7 for default), rerr_o=1, rdata_o=0. A following request completes normally.
- Fairness after wrap: pointer at 3 (last grant to 2), req_i=4'b1001 -> gnt requester 3 first, then 0.
- Reset mid-transaction: deassert rst_ni in WAIT -> all outputs 0 immediately; no rvalid after release. Pointer=0, so simultaneous req 0 and 1 grants 0.
